// File: rtl/cfg_chain_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_chain_pkg : shared types and constants for the config chain   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package cfg_chain_pkg;

  localparam int CHAIN_WIDTH = 16;
  localparam int DIV_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_tick_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_tick_div : half-period counter, last_o high on count DIV-1  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module shift_tick_div
  import cfg_chain_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic last_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || last_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfg_chain_shift_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_chain_shift_tx : MSB-first config chain shifter with readback |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module cfg_chain_shift_tx
  import cfg_chain_pkg::*;
#(
  parameter int WIDTH = CHAIN_WIDTH,
  parameter int DIV   = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             readback_in_i,
  output logic             shift_clk_o,
  output logic             shift_dta_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] readback_o,
  output logic             match_o
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             match_q, match_d;
  logic             sclk_q, sclk_d;
  logic             dta_q, dta_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_last;

  shift_tick_div #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == IDLE),
    .last_o  (tick_last)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    cap_d   = cap_q;
    prev_d  = prev_q;
    rb_d    = rb_q;
    match_d = match_q;
    dta_d   = dta_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_d    = word_i;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Sample the chain tail before the rising edge shifts it.
        if (tick_last) begin
          cap_d   = {cap_q[WIDTH-2:0], readback_in_i};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick_last) begin
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rb_d    = cap_q;
            match_d = (cap_q == prev_q);
            prev_d  = tx_q;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so pins never glitch.
    sclk_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    if (state_d == SETUP) begin
      dta_d = tx_d[LAST_BIT - bit_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      cap_q   <= '0;
      prev_q  <= '0;
      rb_q    <= '0;
      match_q <= 1'b0;
      sclk_q  <= 1'b0;
      dta_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      cap_q   <= cap_d;
      prev_q  <= prev_d;
      rb_q    <= rb_d;
      match_q <= match_d;
      sclk_q  <= sclk_d;
      dta_q   <= dta_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign shift_clk_o = sclk_q;
  assign shift_dta_o = dta_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign readback_o  = rb_q;
  assign match_o     = match_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_shift_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cfg_chain_shift_tx : DIV=2 and DIV=1 instances with chain model|
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_cfg_chain_shift_tx;

  typedef struct {
    int   cyc;
    logic dta;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        start [2];
  logic [15:0] word  [2];
  logic        rbin  [2];
  logic        sclk  [2];
  logic        sdta  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] rb    [2];
  logic        match [2];

  logic [15:0] chain [2] = '{16'h0, 16'h0};
  logic        mprev [2] = '{1'b0, 1'b0};
  logic        corrupt_req = 1'b0;
  logic [15:0] corrupt_val = 16'h0;

  exp_t q [2][$];
  int   exp_done [2];
  logic sp [2];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cfg_chain_shift_tx #(.WIDTH(16), .DIV(2)) u_dut2 (
    .clk(clk), .rst(rst[0]), .start_i(start[0]), .word_i(word[0]),
    .readback_in_i(rbin[0]), .shift_clk_o(sclk[0]), .shift_dta_o(sdta[0]),
    .busy_o(busy[0]), .done_o(done[0]), .readback_o(rb[0]), .match_o(match[0])
  );

  cfg_chain_shift_tx #(.WIDTH(16), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start_i(start[1]), .word_i(word[1]),
    .readback_in_i(rbin[1]), .shift_clk_o(sclk[1]), .shift_dta_o(sdta[1]),
    .busy_o(busy[1]), .done_o(done[1]), .readback_o(rb[1]), .match_o(match[1])
  );

  assign rbin[0] = chain[0][15];
  assign rbin[1] = chain[1][15];

  // Chain model: shifts on each observed shift_clk rising edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mprev[d] <= sclk[d];
      if (d == 0 && corrupt_req) chain[d] <= corrupt_val;
      else if (sclk[d] && !mprev[d]) chain[d] <= {chain[d][14:0], sdta[d]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (sclk[d] && !sp[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("unexpected_edge%0d", d), 32'd1, 32'd0);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("edge_cycle%0d", d), cyc, e.cyc);
          chk($sformatf("edge_dta%0d", d), 32'(sdta[d]), 32'(e.dta));
        end
      end
      sp[d] = sclk[d];
      chk($sformatf("done%0d", d), 32'(done[d]), 32'(cyc == exp_done[d]));
      chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(exp_done[d] > cyc));
      if (cyc == exp_done[d]) begin
        chk($sformatf("edges_left%0d", d), q[d].size(), 0);
        exp_done[d] = -1;
      end
    end
  endtask

  task automatic push_xfer(input int d, input logic [15:0] w);
    exp_t e;
    int   dv;
    dv = (d == 0) ? 2 : 1;
    for (int k = 0; k < 16; k++) begin
      e.cyc = cyc + 1 + dv + 2 * dv * k;
      e.dta = w[15-k];
      q[d].push_back(e);
    end
    exp_done[d] = cyc + 1 + 2 * dv * 16;
  endtask

  task automatic wait_done(input int d);
    int g;
    g = 0;
    while (exp_done[d] >= 0 && g < 200) begin
      step();
      g++;
    end
    if (exp_done[d] >= 0) begin
      chk($sformatf("done_timeout%0d", d), 32'd1, 32'd0);
      exp_done[d] = -1;
      q[d].delete();
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_sclk%0d", tag, d), 32'(sclk[d]), 32'd0);
    chk($sformatf("%s_dta%0d", tag, d), 32'(sdta[d]), 32'd0);
    chk($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'd0);
    chk($sformatf("%s_done%0d", tag, d), 32'(done[d]), 32'd0);
    chk($sformatf("%s_rb%0d", tag, d), 32'(rb[d]), 32'd0);
    chk($sformatf("%s_match%0d", tag, d), 32'(match[d]), 32'd0);
  endtask

  initial begin
    exp_done = '{-1, -1};
    rst   = '{1'b1, 1'b1};
    start = '{1'b0, 1'b0};
    word  = '{16'h0, 16'h0};
    repeat (2) @(posedge clk);
    #1;
    sp[0] = sclk[0];
    sp[1] = sclk[1];
    step();
    rst = '{1'b0, 1'b0};
    repeat (10) begin
      step();
      chk_zero(0, "reset");
      chk_zero(1, "reset");
    end

    // Basic transfer into an empty chain.
    word[0] = 16'hA5C3; start[0] = 1'b1; push_xfer(0, 16'hA5C3);
    step(); start[0] = 1'b0;
    wait_done(0);
    chk("t1_rb", 32'(rb[0]), 32'h0000);
    chk("t1_match", 32'(match[0]), 32'd1);
    step();
    chk("t1_chain", 32'(chain[0]), 32'hA5C3);

    // Second transfer with a stray start at cycle 20.
    word[0] = 16'h1234; start[0] = 1'b1; push_xfer(0, 16'h1234);
    step(); start[0] = 1'b0;
    repeat (19) step();
    start[0] = 1'b1;
    step(); start[0] = 1'b0;
    wait_done(0);
    chk("t2_rb", 32'(rb[0]), 32'hA5C3);
    chk("t2_match", 32'(match[0]), 32'd1);
    step();
    chk("t2_chain", 32'(chain[0]), 32'h1234);

    corrupt_val = 16'h1235; corrupt_req = 1'b1;
    step(); corrupt_req = 1'b0;
    step();
    chk("corrupt_chain", 32'(chain[0]), 32'h1235);

    // start held through done; word changed after acceptance.
    word[0] = 16'h0000; start[0] = 1'b1; push_xfer(0, 16'h0000);
    step(); word[0] = 16'h5A5A;
    wait_done(0);
    chk("t3_rb", 32'(rb[0]), 32'h1235);
    chk("t3_match", 32'(match[0]), 32'd0);
    push_xfer(0, 16'h5A5A);
    step(); start[0] = 1'b0;
    wait_done(0);
    chk("t4_rb", 32'(rb[0]), 32'h0000);
    chk("t4_match", 32'(match[0]), 32'd1);
    step();
    chk("t4_chain", 32'(chain[0]), 32'h5A5A);

    // Reset at cycle 30 of a transfer.
    word[0] = 16'hC3C3; start[0] = 1'b1; push_xfer(0, 16'hC3C3);
    step(); start[0] = 1'b0;
    repeat (29) step();
    rst[0] = 1'b1; q[0].delete(); exp_done[0] = -1;
    step();
    chk_zero(0, "midrst");
    rst[0] = 1'b0;
    repeat (10) step();

    word[0] = 16'hFFFF; start[0] = 1'b1; push_xfer(0, 16'hFFFF);
    step(); start[0] = 1'b0;
    wait_done(0);
    step();
    chk("t6_chain", 32'(chain[0]), 32'hFFFF);

    // DIV=1 instance.
    word[1] = 16'h8001; start[1] = 1'b1; push_xfer(1, 16'h8001);
    step(); start[1] = 1'b0;
    wait_done(1);
    chk("d1_rb", 32'(rb[1]), 32'h0000);
    chk("d1_match", 32'(match[1]), 32'd1);
    step();
    chk("d1_chain", 32'(chain[1]), 32'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cfg_chain_shift_tx.md
# cfg_chain_shift_tx

Serial transmitter for the 16-bit configuration shift chain that programs the ring-oscillator taps. It drives the chain's `shift_clk`/`shift_dta` pins from a parallel word, and generates a slow, glitch-free shift clock from the system clock. During each transfer it captures the chain's serial output (last stage) to read back the previous chain contents. It sits in the test/controller harness driving the clock-source user module.

## Interface
Parameters:
- `WIDTH`, 16: chain length and word width.
- `DIV`, 2: system-clock cycles per shift_clk half-period; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `word`  in  WIDTH  word to program; captured on the accepted `start` cycle.
- `readback_in`  in  1  chain last-stage output (`shifter[WIDTH-1]`).
- `shift_clk`  out  1  chain shift clock, registered.
- `shift_dta`  out  1  chain serial data, registered.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse at transfer completion.
- `readback`  out  WIDTH  chain contents before the latest completed transfer.
- `match`  out  1  `readback` equals the word of the previous completed transfer.

## Operation
- States: IDLE, SETUP, HIGH. Bit counter `0..WIDTH-1`. Half-period counter `0..DIV-1`.
- IDLE: `shift_clk`=0, `busy`=0. On `start`=1, latch `word` into the TX register and go to SETUP with bit 0. Set `busy`=1 from the next cycle.
- Bit order: MSB first, so that after WIDTH pulses the chain holds `shifter[i] = word[i]`.
- SETUP (DIV cycles): `shift_dta` = current TX bit and `shift_clk`=0. On the last SETUP cycle, shift `readback_in` into the capture register LSB-in (MSB arrives first). Then go to HIGH.
- HIGH (DIV cycles): `shift_clk`=1 and `shift_dta` held. After the last cycle, advance to the next bit and go to SETUP. After bit WIDTH-1, instead go to IDLE, pulse `done`, and update outputs:
  - `readback` ← capture register.
  - `match` ← (capture == previous word).
  - previous word ← TX word.
- `shift_dta` changes only while `shift_clk`=0. This gives DIV cycles of setup and DIV cycles of hold around every rising edge.
- `start` while busy: ignored, not queued. `start` in the same cycle as `done`: accepted, because the FSM is already in IDLE.
- `word` changes after acceptance have no effect.

## Timing
- Reset values:
  - `shift_clk`=0, `shift_dta`=0, `busy`=0, `done`=0.
  - `readback`=0, `match`=0, previous word=0.
  - FSM in IDLE.
- Transfer timing, with `start` accepted at cycle 0:
  - Bit k SETUP occupies cycles `1+2·DIV·k` through `DIV+2·DIV·k`.
  - shift_clk rises at cycle `1+DIV+2·DIV·k`.
  - `done` and the updated `readback`/`match` appear at cycle `1+2·DIV·WIDTH`. `busy` is low in that cycle.
- Back-to-back transfers: the minimum start-to-start interval is `1+2·DIV·WIDTH` cycles.
- Reset mid-transfer:
  - The next cycle returns all outputs to reset values; `shift_clk` drops to 0 with no extra edge.
  - The chain is left partially shifted.
  - `match` is cleared, and no `done` pulse is issued.
- The readback sample is taken in the cycle before the rising edge, so `readback_in` is the pre-shift value.

## Structure
- Shared package `cfg_chain_pkg`:
  - state enum `{IDLE, SETUP, HIGH}`;
  - `CHAIN_WIDTH=16` constant;
  - default `DIV` constant.
- Sub-module `shift_tick_div`: half-period counter with a `clear` input and a `last` output (high on count DIV-1). It resets synchronously with `rst`.
- All other logic is in `cfg_chain_shift_tx`: FSM, bit counter, TX, capture and previous-word registers.

## Test plan
Bench: WIDTH=16, DIV=2, with a behavioural 16-bit chain model clocked by `shift_clk` driving `readback_in`.
- Reset check: after reset, all outputs are 0 → hold for 10 cycles; no `shift_clk` edges.
- Basic transfer: `start` with `word`=16'hA5C3 at cycle 0 →
  - `shift_dta` sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1;
  - 16 rising edges at cycles 3,7,…,63;
  - `done` at cycle 65;
  - chain model = 16'hA5C3.
- Readback and match: second transfer with 16'h1234 → `readback`=16'hA5C3, `match`=1. Third transfer with 16'h0000 after the chain model is corrupted to 16'h1235 → `readback`=16'h1235, `match`=0.
- `start` handling:
  - pulse `start` at cycle 20 of a transfer → ignored; exactly 16 edges occur;
  - `start` held high through `done` → the next transfer begins at the `done` cycle.
- Mid-transfer reset: assert `rst` at cycle 30 → next cycle all outputs 0, no `done`. A following full transfer of 16'hFFFF leaves chain = 16'hFFFF.
- DIV=1 variant: `word`=16'h8001 → edges every 2 cycles, `done` at cycle 33.
